// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch/decode sequencer.
// Reads one or two bytes per instruction from program memory, drives the
// PC block (increment / load), strobes the datapath for executable ops and
// waits for its completion. Opcode HLT_OP parks the sequencer until reset.
module fetch_ctrl #(
  parameter logic [7:0] HLT_OP = 8'h3F
) (
  input  logic       CLK,
  input  logic       CLRn,
  input  logic [7:0] PC_Q,
  output logic       IPC,
  output logic       LDn,
  output logic [7:0] PC_D,
  output logic [7:0] MEM_ADDR,
  output logic       MEM_RDn,
  input  logic [7:0] MEM_DATA,
  input  logic       MEM_RDY,
  input  logic       ZF,
  output logic [7:0] IR,
  output logic [7:0] OPR,
  output logic       EXEC_STB,
  input  logic       EXEC_DONE,
  output logic       HALTED
);

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_OPND  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_JUMP  = 3'd4,
    ST_HALT  = 3'd5
  } state_t;

  // Instruction classes taken from the top two opcode bits.
  localparam logic [1:0] CLS_ONE = 2'b00;
  localparam logic [1:0] CLS_TWO = 2'b01;
  localparam logic [1:0] CLS_JMP = 2'b10;
  localparam logic [1:0] CLS_JZ  = 2'b11;

  state_t state;
  state_t state_nxt;
  logic   rd_phase;

  // The jump target is always the operand register.
  assign PC_D = OPR;

  // Memory request and PC increment follow the read states directly so that
  // a zero-wait memory is consumed in the same cycle. CLRn gates the request
  // so nothing is asked of memory while reset is held.
  always_comb begin
    rd_phase = CLRn && ((state == ST_FETCH) || (state == ST_OPND));
    MEM_RDn  = !rd_phase;
    MEM_ADDR = rd_phase ? PC_Q : 8'h00;
    IPC      = rd_phase && MEM_RDY;
  end

  // Next-state decode; opcode byte is decoded as it arrives in FETCH, the
  // operand class comes from the already captured IR in OPND.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_FETCH: begin
        if (MEM_RDY) begin
          if (MEM_DATA == HLT_OP)               state_nxt = ST_HALT;
          else if (MEM_DATA[7:6] == CLS_ONE)    state_nxt = ST_EXEC;
          else                                  state_nxt = ST_OPND;
        end
      end
      ST_OPND: begin
        if (MEM_RDY) begin
          case (IR[7:6])
            CLS_TWO: state_nxt = ST_EXEC;
            CLS_JMP: state_nxt = ST_JUMP;
            CLS_JZ:  state_nxt = ZF ? ST_JUMP : ST_FETCH;
            default: state_nxt = ST_FETCH;
          endcase
        end
      end
      ST_EXEC:  state_nxt = EXEC_DONE ? ST_FETCH : ST_WAIT;
      ST_WAIT:  state_nxt = EXEC_DONE ? ST_FETCH : ST_WAIT;
      ST_JUMP:  state_nxt = ST_FETCH;
      ST_HALT:  state_nxt = ST_HALT;
      default:  state_nxt = ST_FETCH;
    endcase
  end

  // State, instruction/operand capture and registered strobes. Strobes are
  // decoded from the next state so they are high for exactly the cycle spent
  // in EXEC / JUMP / HALT; reset clears them immediately.
  always_ff @(posedge CLK or negedge CLRn) begin
    if (!CLRn) begin
      state    <= ST_FETCH;
      IR       <= 8'h00;
      OPR      <= 8'h00;
      EXEC_STB <= 1'b0;
      LDn      <= 1'b1;
      HALTED   <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == ST_FETCH) && MEM_RDY) IR  <= MEM_DATA;
      if ((state == ST_OPND)  && MEM_RDY) OPR <= MEM_DATA;
      EXEC_STB <= (state_nxt == ST_EXEC);
      LDn      <= (state_nxt != ST_JUMP);
      HALTED   <= (state_nxt == ST_HALT);
    end
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter: HLT_OP, 8'h3F, opcode that halts the sequencer.
REQ-002 CLK  input  1  system clock; all state changes on rising edge.
REQ-003 CLRn  input  1  reset; asynchronous, active-low.
REQ-004 PC_Q  input  8  current program counter value from the PC block.
REQ-005 IPC  output  1  PC increment enable, active-high, to the PC block.
REQ-006 LDn  output  1  PC load enable, active-low, to the PC block.
REQ-007 PC_D  output  8  PC load value (jump target).
REQ-008 MEM_ADDR  output  8  program memory address.
REQ-009 MEM_RDn  output  1  memory read request, active-low.
REQ-010 MEM_DATA  input  8  memory read data, valid when MEM_RDY=1.
REQ-011 MEM_RDY  input  1  memory read acknowledge, active-high.
REQ-012 ZF  input  1  zero flag from the ALU, sampled for JZ.
REQ-013 IR  output  8  instruction register.
REQ-014 OPR  output  8  operand register.
REQ-015 EXEC_STB  output  1  one-cycle execute strobe to the datapath.
REQ-016 EXEC_DONE  input  1  datapath completion, active-high.
REQ-017 HALTED  output  1  high while in HALT.

Function
REQ-018 States SHALL be FETCH, OPND, EXEC, WAIT, JUMP, HALT.
REQ-019 FETCH/OPND: MEM_ADDR=PC_Q, MEM_RDn=0; elsewhere MEM_ADDR=8'h00, MEM_RDn=1.
REQ-020 FETCH: on MEM_RDY=1 -> IR<=MEM_DATA, IPC=1 that cycle; MEM_RDY=0 -> hold state, IPC=0.
REQ-021 Decode of the captured byte, IR[7:6]: 00 one-byte op, 01 two-byte op, 10 JMP, 11 JZ.
REQ-022 From FETCH: byte==HLT_OP -> HALT; class 00 -> EXEC; classes 01/10/11 -> OPND.
REQ-023 OPND: on MEM_RDY=1 -> OPR<=MEM_DATA, IPC=1 that cycle; next: class 01 -> EXEC; JMP -> JUMP; JZ with ZF=1 (sampled that cycle) -> JUMP; JZ with ZF=0 -> FETCH.
REQ-024 IPC SHALL be asserted only in FETCH/OPND with MEM_RDY=1 (one cycle per byte consumed).
REQ-025 EXEC: EXEC_STB=1 for exactly its one cycle; EXEC_DONE=1 same cycle -> FETCH, else -> WAIT.
REQ-026 WAIT: EXEC_STB=0; EXEC_DONE=1 -> FETCH; hold otherwise, no timeout.
REQ-027 JUMP: one cycle, LDn=0, PC_D=OPR, then FETCH; LDn=1 in all other states.
REQ-028 IPC=1 and LDn=0 SHALL never coincide.
REQ-029 HALT: HALTED=1, no memory requests, IPC=0, LDn=1; exit only via reset.
REQ-030 PC_D SHALL equal OPR in all states.
REQ-031 IR/OPR hold their value until the next accepted byte of the same kind.
REQ-032 Latency: one-byte op with zero-wait memory and EXEC_DONE tied high = 2 cycles; JMP = 3 cycles to first fetch at target.
REQ-033 PC wrap 8'hFF->8'h00 is the PC block's concern; no special handling here.

Reset
REQ-034 CLRn=0 SHALL immediately force: state FETCH, IR=8'h00, OPR=8'h00, IPC=0, LDn=1, EXEC_STB=0, HALTED=0, MEM_RDn=1.
REQ-035 Reset mid-transaction (any state incl. WAIT/HALT) SHALL abandon it; no strobe or PC load may issue after CLRn falls.
REQ-036 After CLRn rises, first rising edge evaluates FETCH with MEM_RDn=0 at MEM_ADDR=PC_Q.

Verification
REQ-037 Reset release, memory {00:8'h05}, MEM_RDY=1, EXEC_DONE=1 -> IR=8'h05, one IPC pulse, EXEC_STB one cycle, back in FETCH at PC 01.
REQ-038 {00:8'h80,01:8'h20} JMP -> OPR=8'h20, two IPC pulses, then LDn=0 one cycle with PC_D=8'h20, next MEM_ADDR=8'h20.
REQ-039 JZ {8'hC0,8'h40}: ZF=1 -> LDn pulse, PC_D=8'h40; ZF=0 -> no LDn, next fetch at PC 02.
REQ-040 MEM_RDY low 3 cycles in FETCH -> MEM_RDn held 0, IPC=0, IR unchanged until MEM_RDY=1.
REQ-041 Two-byte op 8'h41,8'h7A with EXEC_DONE delayed 4 cycles -> OPR=8'h7A, EXEC_STB single pulse, stays WAIT 4 cycles.
REQ-042 Fetch 8'h3F -> HALTED=1, no further MEM_RDn/IPC; CLRn pulse low during HALT -> HALTED=0 asynchronously, fetching resumes.
